// File: rtl/vshift_pkg.sv
// Shared definitions for the vector shift pipeline: mode encoding and
// sizing helper for the clamped per-lane shift amount.
package vshift_pkg;

    typedef enum logic [1:0] {
        ASR = 2'd0,
        LSL = 2'd1,
        LSR = 2'd2,
        RND = 2'd3
    } vshift_mode_e;

    function automatic int amt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/vshift_lane.sv
// One lane of the vector shifter: purely combinational shift, round and
// saturate on an amount already clamped to the range 0..WIDTH.
module vshift_lane
    import vshift_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SAT   = 1,
    parameter int AMT_W = 7
) (
    input  vshift_mode_e       mode,
    input  logic [WIDTH-1:0]   x,
    input  logic [AMT_W-1:0]   amt,
    output logic [WIDTH-1:0]   y,
    output logic               sat
);

    logic signed [WIDTH:0]     x_ext;
    logic signed [WIDTH:0]     rnd_bias;
    logic signed [WIDTH:0]     rnd_sum;
    logic signed [WIDTH:0]     asr_wide;
    logic signed [WIDTH:0]     rnd_wide;
    logic [2*WIDTH-1:0]        lsl_wide;
    logic                      lsl_ovf;

    // Shift/round/saturate datapath selected by the shared mode
    always_comb begin
        y        = '0;
        sat      = 1'b0;
        x_ext    = {x[WIDTH-1], x};
        // One extra bit keeps x + 2^(s-1) free of overflow
        rnd_bias = {{WIDTH{1'b0}}, 1'b1} << (amt - AMT_W'(1));
        rnd_sum  = x_ext + rnd_bias;
        asr_wide = x_ext >>> amt;
        rnd_wide = rnd_sum >>> amt;
        lsl_wide = {{WIDTH{x[WIDTH-1]}}, x} << amt;
        lsl_ovf  = (lsl_wide[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){x[WIDTH-1]}});
        case (mode)
            ASR: begin
                y = asr_wide[WIDTH-1:0];
            end
            LSL: begin
                if ((SAT != 0) && lsl_ovf) begin
                    y   = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                    sat = 1'b1;
                end else begin
                    y   = lsl_wide[WIDTH-1:0];
                    sat = 1'b0;
                end
            end
            LSR: begin
                y = x >> amt;
            end
            RND: begin
                if (amt == AMT_W'(0)) begin
                    y = x;
                end else begin
                    y = rnd_wide[WIDTH-1:0];
                end
            end
            default: begin
                y   = '0;
                sat = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/vshift_pipe.sv
// Two-stage multi-lane shift pipeline with a single valid/ready pair:
// S1 holds operands and clamped amounts, S2 holds the lane results.
module vshift_pipe
    import vshift_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int LANES   = 4,
    parameter int SHAMT_W = 8,
    parameter int SAT     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vshift_in_valid,
    output logic                     vshift_in_ready,
    input  logic [1:0]               vshift_mode,
    input  logic [LANES*WIDTH-1:0]   vshift_i1,
    input  logic [LANES*SHAMT_W-1:0] vshift_i2,
    output logic                     vshift_out_valid,
    input  logic                     vshift_out_ready,
    output logic [LANES*WIDTH-1:0]   vshift_o,
    output logic [LANES-1:0]         vshift_sat
);

    localparam int AMT_W = amt_width(WIDTH);

    logic                          en;
    logic                          s1_valid_d, s1_valid_q;
    vshift_mode_e                  s1_mode_d,  s1_mode_q;
    logic [LANES*WIDTH-1:0]        s1_x_d,     s1_x_q;
    logic [LANES-1:0][AMT_W-1:0]   s1_amt_d,   s1_amt_q;
    logic                          s2_valid_d, s2_valid_q;
    logic [LANES*WIDTH-1:0]        s2_y_d,     s2_y_q;
    logic [LANES-1:0]              s2_sat_d,   s2_sat_q;
    logic [LANES*WIDTH-1:0]        lane_y;
    logic [LANES-1:0]              lane_sat;
    logic [SHAMT_W-1:0]            amt_raw;

    // Both stages move together whenever the output slot is free or draining
    always_comb begin
        en         = !s2_valid_q || vshift_out_ready;
        amt_raw    = '0;
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_x_d     = s1_x_q;
        s1_amt_d   = s1_amt_q;
        s2_valid_d = s2_valid_q;
        s2_y_d     = s2_y_q;
        s2_sat_d   = s2_sat_q;
        if (en) begin
            s1_valid_d = vshift_in_valid;
            s1_mode_d  = vshift_mode_e'(vshift_mode);
            s1_x_d     = vshift_i1;
            for (int k = 0; k < LANES; k++) begin
                amt_raw = vshift_i2[k*SHAMT_W +: SHAMT_W];
                if (32'(amt_raw) >= 32'(WIDTH)) begin
                    s1_amt_d[k] = AMT_W'(WIDTH);
                end else begin
                    s1_amt_d[k] = AMT_W'(amt_raw);
                end
            end
            s2_valid_d = s1_valid_q;
            s2_y_d     = lane_y;
            s2_sat_d   = lane_sat;
        end else begin
            s1_valid_d = s1_valid_q;
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset drops every in-flight and incoming transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= ASR;
            s1_x_q     <= '0;
            s1_amt_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
            s2_sat_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_x_q     <= s1_x_d;
            s1_amt_q   <= s1_amt_d;
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
            s2_sat_q   <= s2_sat_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        vshift_lane #(
            .WIDTH (WIDTH),
            .SAT   (SAT),
            .AMT_W (AMT_W)
        ) u_lane (
            .mode (s1_mode_q),
            .x    (s1_x_q[k*WIDTH +: WIDTH]),
            .amt  (s1_amt_q[k]),
            .y    (lane_y[k*WIDTH +: WIDTH]),
            .sat  (lane_sat[k])
        );
    end

    assign vshift_in_ready  = en;
    assign vshift_out_valid = s2_valid_q;
    assign vshift_o         = s2_y_q;
    assign vshift_sat       = s2_sat_q;

endmodule

// File: tb/tb_vshift_pipe.sv
// Directed and randomized checks of vshift_pipe (WIDTH=16, LANES=2, SAT=1)
// against an arithmetic reference model and an in-order expectation queue.
module tb_vshift_pipe;

    localparam int W = 16;
    localparam int L = 2;
    localparam int S = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            vshift_in_valid = 1'b0;
    logic            vshift_in_ready;
    logic [1:0]      vshift_mode = 2'd0;
    logic [L*W-1:0]  vshift_i1 = '0;
    logic [L*S-1:0]  vshift_i2 = '0;
    logic            vshift_out_valid;
    logic            vshift_out_ready = 1'b1;
    logic [L*W-1:0]  vshift_o;
    logic [L-1:0]    vshift_sat;

    vshift_pipe #(.WIDTH(W), .LANES(L), .SHAMT_W(S), .SAT(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .vshift_in_valid  (vshift_in_valid),
        .vshift_in_ready  (vshift_in_ready),
        .vshift_mode      (vshift_mode),
        .vshift_i1        (vshift_i1),
        .vshift_i2        (vshift_i2),
        .vshift_out_valid (vshift_out_valid),
        .vshift_out_ready (vshift_out_ready),
        .vshift_o         (vshift_o),
        .vshift_sat       (vshift_sat)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    int              n_out = 0;
    logic [33:0]     exp_q[$];
    logic [33:0]     next_exp = '0;
    logic [33:0]     got;
    logic [33:0]     want;
    bit              accepted = 1'b0;
    bit              prev_stall = 1'b0;
    logic [L*W-1:0]  prev_o = '0;
    logic [L-1:0]    prev_sat = '0;

    function automatic longint fdiv(input longint n, input longint d);
        return (n >= 0) ? n / d : -((-n + d - 1) / d);
    endfunction

    // Returns {sat, result} for one lane straight from the arithmetic definitions
    function automatic logic [16:0] ref_lane(input logic [1:0] m, input logic [15:0] xb, input logic [7:0] sb);
        longint x, d, p, r;
        int     s, sc;
        logic   st;
        x  = longint'($signed(xb));
        s  = int'(sb);
        sc = (s > 16) ? 16 : s;
        d  = 1;
        for (int i = 0; i < sc; i++) d = d * 2;
        st = 1'b0;
        case (m)
            2'd0: r = (s >= 16) ? ((x < 0) ? -1 : 0) : fdiv(x, d);
            2'd2: r = (s >= 16) ? 0 : (x & 65535) / d;
            2'd3: r = (s == 0) ? x : ((s >= 16) ? 0 : fdiv(x + d / 2, d));
            default: begin
                p = x * d;
                if (p > 32767) begin
                    r = 32767; st = 1'b1;
                end else if (p < -32768) begin
                    r = -32768; st = 1'b1;
                end else begin
                    r = p;
                end
            end
        endcase
        return {st, r[15:0]};
    endfunction

    task automatic tick();
        #1;
        if (prev_stall) begin
            checks++;
            assert (vshift_out_valid === 1'b1 && vshift_o === prev_o && vshift_sat === prev_sat)
            else begin
                errors++;
                $error("FAIL stall_hold: observed valid=%0b o=%h sat=%b, expected valid=1 o=%h sat=%b",
                       vshift_out_valid, vshift_o, vshift_sat, prev_o, prev_sat);
            end
        end
        if (!rst && vshift_out_valid && vshift_out_ready) begin
            n_out++;
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_out: observed o=%h sat=%b, expected no output", vshift_o, vshift_sat);
            end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = {vshift_sat, vshift_o};
                checks++;
                assert (got === want)
                else begin
                    errors++;
                    $error("FAIL result: observed sat=%b o=%h, expected sat=%b o=%h",
                           got[33:32], got[31:0], want[33:32], want[31:0]);
                end
            end
        end
        accepted = !rst && vshift_in_valid && vshift_in_ready;
        if (accepted) exp_q.push_back(next_exp);
        prev_stall = !rst && vshift_out_valid && !vshift_out_ready;
        prev_o     = vshift_o;
        prev_sat   = vshift_sat;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] i1, input logic [15:0] i2, input logic [33:0] e);
        vshift_in_valid = 1'b1;
        vshift_mode     = m;
        vshift_i1       = i1;
        vshift_i2       = i2;
        next_exp        = e;
        accepted        = 1'b0;
        for (int n = 0; n < 50 && !accepted; n++) tick();
        checks++;
        assert (accepted)
        else begin
            errors++;
            $error("FAIL send_timeout: observed in_ready=%0b, expected acceptance within 50 cycles", vshift_in_ready);
        end
        vshift_in_valid = 1'b0;
    endtask

    task automatic drain();
        vshift_in_valid  = 1'b0;
        vshift_out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL drain: observed %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic rand_inputs();
        logic [15:0] x[2];
        logic [7:0]  s[2];
        logic [16:0] r0, r1;
        for (int k = 0; k < 2; k++) begin
            case ($urandom_range(0, 5))
                0: x[k] = 16'h8000;
                1: x[k] = 16'h7FFF;
                2: x[k] = 16'h0000;
                default: x[k] = 16'($urandom);
            endcase
            s[k] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
        end
        vshift_mode = 2'($urandom_range(0, 3));
        vshift_i1   = {x[1], x[0]};
        vshift_i2   = {s[1], s[0]};
        r0 = ref_lane(vshift_mode, x[0], s[0]);
        r1 = ref_lane(vshift_mode, x[1], s[1]);
        next_exp = {r1[16], r0[16], r1[15:0], r0[15:0]};
    endtask

    initial begin
        int n0;
        int sent;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        assert (vshift_out_valid === 1'b0 && vshift_o === 32'h0 && vshift_sat === 2'b00 && vshift_in_ready === 1'b1)
        else begin
            errors++;
            $error("FAIL reset_state: observed valid=%0b o=%h sat=%b in_ready=%0b, expected 0/0/0/1",
                   vshift_out_valid, vshift_o, vshift_sat, vshift_in_ready);
        end
        @(negedge clk);

        // ASR with two-cycle latency check
        send(2'd0, {16'h8000, 16'h8000}, {8'd20, 8'd3}, {2'b00, 16'hFFFF, 16'hF000});
        checks++;
        assert (vshift_out_valid === 1'b0)
        else begin errors++; $error("FAIL latency_c1: observed out_valid=%0b, expected 0", vshift_out_valid); end
        tick();
        checks++;
        assert (vshift_out_valid === 1'b1)
        else begin errors++; $error("FAIL latency_c2: observed out_valid=%0b, expected 1", vshift_out_valid); end
        drain();

        // RND, LSL saturation and lane-independent LSR
        send(2'd3, {16'hFFFB, 16'h0005}, {8'd1, 8'd1}, {2'b00, 16'hFFFE, 16'h0003});
        send(2'd3, {16'h0000, 16'h7FFF}, {8'd0, 8'd1}, {2'b00, 16'h0000, 16'h4000});
        send(2'd1, {16'hFFFE, 16'h4000}, {8'd3, 8'd1}, {2'b01, 16'hFFF0, 16'h7FFF});
        send(2'd1, {16'h0000, 16'h0001}, {8'd16, 8'd16}, {2'b01, 16'h0000, 16'h7FFF});
        send(2'd2, {16'h1234, 16'h8000}, {8'd0, 8'd15}, {2'b00, 16'h1234, 16'h0001});
        drain();

        // Backpressure: 8 transactions with out_ready low for 3 cycles
        n0   = n_out;
        sent = 0;
        for (int c = 0; c < 80 && (sent < 8 || exp_q.size() != 0); c++) begin
            vshift_out_ready = !(c >= 4 && c < 7);
            if (sent < 8) begin
                rand_inputs();
                vshift_in_valid = 1'b1;
            end else begin
                vshift_in_valid = 1'b0;
            end
            tick();
            if (accepted) sent++;
        end
        vshift_in_valid = 1'b0;
        checks++;
        assert (n_out - n0 == 8 && sent == 8)
        else begin
            errors++;
            $error("FAIL backpressure_count: observed sent=%0d received=%0d, expected 8/8", sent, n_out - n0);
        end
        drain();

        // Reset with two transactions in flight
        vshift_out_ready = 1'b0;
        send(2'd0, {16'h1111, 16'h2222}, {8'd1, 8'd1}, {2'b00, 16'h0888, 16'h1111});
        send(2'd0, {16'h3333, 16'h4444}, {8'd2, 8'd2}, {2'b00, 16'h0CCC, 16'h1111});
        rst = 1'b1;
        vshift_in_valid = 1'b1;
        next_exp = '0;
        tick();
        rst = 1'b0;
        vshift_in_valid = 1'b0;
        #1;
        checks++;
        assert (vshift_out_valid === 1'b0 && vshift_in_ready === 1'b1 && vshift_o === 32'h0)
        else begin
            errors++;
            $error("FAIL reset_flush: observed valid=%0b in_ready=%0b o=%h, expected 0/1/0",
                   vshift_out_valid, vshift_in_ready, vshift_o);
        end
        @(negedge clk);
        vshift_out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++;
            assert (vshift_out_valid === 1'b0)
            else begin errors++; $error("FAIL reset_ghost: observed out_valid=%0b, expected 0", vshift_out_valid); end
        end

        // Randomized stream with random backpressure
        for (int c = 0; c < 400; c++) begin
            vshift_out_ready = ($urandom_range(0, 3) != 0);
            vshift_in_valid  = ($urandom_range(0, 4) != 0);
            rand_inputs();
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
